n2t_serial_loader: RTL and testbench

//  Write-side driver for a 16-bit Hack register/RAM port: it produces the in/load pair that the register consumes.

---
 rtl/n2t_serial_loader_pkg.sv | 14 +
 rtl/n2t_serial_loader_if.sv | 26 ++
 rtl/n2t_shiftreg.sv | 36 +++
 rtl/n2t_serial_loader.sv | 113 +++++++++++
 tb/tb_n2t_serial_loader.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/n2t_serial_loader_pkg.sv
// Shared types and constants for the Hack serial loader.
// The PARITY_CHECK_EN build macro enables the trailing even-parity bit.
package n2t_serial_loader_pkg;

  localparam int unsigned N2T_WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StLoad   = 2'd3
  } state_e;

endpackage

// File: rtl/n2t_serial_loader_if.sv
// Serial-in / word-out bundle between a bit source, the loader and a Hack register port.
interface n2t_serial_loader_if
  import n2t_serial_loader_pkg::*;
#(
  parameter int unsigned Width = N2T_WORD_W
) ();

  logic             start;
  logic             sdata;
  logic             bit_valid;
  logic [Width-1:0] word;
  logic             load;
  logic             busy;
  logic             err;

  modport master (
    output start, sdata, bit_valid,
    input  word, load, busy, err
  );

  modport slave (
    input  start, sdata, bit_valid,
    output word, load, busy, err
  );

endinterface

// File: rtl/n2t_shiftreg.sv
// MSB-first serial-in/parallel-out shift register with synchronous clear.
// next_o is the value the register holds after the coming edge.
module n2t_shiftreg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             sdata_i,
  output logic [Width-1:0] next_o
);

  logic [Width-1:0] shreg_q;
  logic [Width-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clr_i) begin
      shreg_d = '0;
    end else if (shift_en_i) begin
      shreg_d = {shreg_q[Width-2:0], sdata_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign next_o = shreg_d;

endmodule

// File: rtl/n2t_serial_loader.sv
// Deserialises an MSB-first bitstream into a word and strobes it into a Hack register.
// Define PARITY_CHECK_EN to require a trailing even-parity bit per frame.
module n2t_serial_loader
  import n2t_serial_loader_pkg::*;
#(
  parameter int unsigned Width = N2T_WORD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  n2t_serial_loader_if.slave   bus_io
);

  localparam int unsigned    CntW    = $clog2(Width);
  localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

  state_e           state_q;
  logic [Width-1:0] word_q;
  logic [Width-1:0] shreg_next;
  logic [CntW-1:0]  count_q;
  logic             load_q;
  logic             busy_q;
  logic             err_q;
  logic             shift_en;
`ifdef PARITY_CHECK_EN
  logic             par_q;
`endif

  // start always wins over a coincident data bit
  assign shift_en = (state_q == StShift) && bus_io.bit_valid && !bus_io.start;

  n2t_shiftreg #(
    .Width (Width)
  ) u_shiftreg (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (bus_io.start),
    .shift_en_i (shift_en),
    .sdata_i    (bus_io.sdata),
    .next_o     (shreg_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      count_q <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      load_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus_io.start) begin
        err_q   <= (state_q == StShift) || (state_q == StParity);
        state_q <= StShift;
        busy_q  <= 1'b1;
        count_q <= '0;
`ifdef PARITY_CHECK_EN
        par_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          StShift: begin
            if (bus_io.bit_valid) begin
`ifdef PARITY_CHECK_EN
              par_q <= par_q ^ bus_io.sdata;
`endif
              if (count_q == LastBit) begin
                count_q <= '0;
`ifdef PARITY_CHECK_EN
                state_q <= StParity;
`else
                state_q <= StLoad;
                busy_q  <= 1'b0;
                load_q  <= 1'b1;
                word_q  <= shreg_next;
`endif
              end else begin
                count_q <= count_q + CntW'(1);
              end
            end
          end
`ifdef PARITY_CHECK_EN
          StParity: begin
            if (bus_io.bit_valid) begin
              busy_q <= 1'b0;
              if (par_q == bus_io.sdata) begin
                state_q <= StLoad;
                load_q  <= 1'b1;
                word_q  <= shreg_next;
              end else begin
                state_q <= StIdle;
                err_q   <= 1'b1;
              end
            end
          end
`endif
          StLoad:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus_io.word = word_q;
  assign bus_io.load = load_q;
  assign bus_io.busy = busy_q;
  assign bus_io.err  = err_q;

endmodule

// File: tb/tb_n2t_serial_loader.sv
// Self-checking bench for n2t_serial_loader against a frame-level reference model.
module tb_n2t_serial_loader;

  localparam int W = 16;
`ifdef PARITY_CHECK_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif
  localparam int FL = W + int'(Par);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  n2t_serial_loader_if #(.Width(W)) bus ();

  n2t_serial_loader #(.Width(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame-level view of the loader
  bit         m_active = 1'b0;
  int         m_nb     = 0;
  logic [W-1:0] m_acc  = '0;
  logic [W-1:0] m_word = '0;
  bit         m_par    = 1'b0;
  bit         m_load   = 1'b0;
  bit         m_err    = 1'b0;

  function automatic logic fbit(input logic [W-1:0] v, input int i);
    if (i < W) return v[W-1-i];
    return ^v;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_nb = 0; m_acc = '0; m_word = '0; m_par = 1'b0;
    m_load = 1'b0; m_err = 1'b0;
  endtask

  // Drive one cycle, advance the model, and return observed/expected {load,err,busy,word}
  task automatic step(input logic s, input logic v, input logic d,
                      output logic [W+2:0] got, output logic [W+2:0] exp);
    bus.start = s; bus.bit_valid = v; bus.sdata = d;
    @(posedge clk);
    #1;
    m_load = 1'b0; m_err = 1'b0;
    if (s) begin
      m_err = m_active; m_active = 1'b1; m_nb = 0; m_acc = '0; m_par = 1'b0;
    end else if (m_active && v) begin
      if (m_nb < W) begin
        m_acc = {m_acc[W-2:0], d};
        m_par = m_par ^ d;
        m_nb++;
        if (!Par && m_nb == W) begin
          m_active = 1'b0; m_load = 1'b1; m_word = m_acc;
        end
      end else begin
        m_active = 1'b0;
        if (m_par == d) begin
          m_load = 1'b1; m_word = m_acc;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    got = {bus.load, bus.err, bus.busy, bus.word};
    exp = {m_load, m_err, m_active, m_word};
  endtask

  task automatic test_reset();
    logic [W+2:0] got;
    bus.start = 1'b0; bus.bit_valid = 1'b0; bus.sdata = 1'b0;
    rst = 1'b1;
    #12;
    got = {bus.load, bus.err, bus.busy, bus.word};
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset: got %h want 0", got);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [W+2:0] got, exp;
    int loads = 0, load_at = -1;
    for (int k = 0; k <= FL + 2; k++) begin
      if (k == 0) step(1'b1, 1'b1, 1'b1, got, exp);  // bit beside start must be dropped
      else if (k <= FL) step(1'b0, 1'b1, fbit(16'hA5C3, k - 1), got, exp);
      else step(1'b0, 1'b0, 1'b0, got, exp);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL basic k=%0d: got %h want %h", k, got, exp);
      end
      if (got[W+2]) begin loads++; load_at = k + 1; end
    end
    total++;
    if (loads !== 1 || load_at !== FL + 1) begin
      bad++; $display("FAIL basic_latency: loads=%0d at t%0d want 1 at t%0d", loads, load_at, FL + 1);
    end
    total++;
    if (bus.word !== 16'hA5C3) begin
      bad++; $display("FAIL basic_word: got %h want a5c3", bus.word);
    end
  endtask

  task automatic test_stall();
    logic [W+2:0] got, exp;
    int loads = 0;
    step(1'b1, 1'b0, 1'b0, got, exp);
    for (int i = 0; i < 2 * FL + 3; i++) begin
      if (i >= 2 * FL) step(1'b0, 1'b0, 1'b0, got, exp);
      else if (i % 2 == 0) step(1'b0, 1'b0, 1'($urandom), got, exp);
      else step(1'b0, 1'b1, fbit(16'h1234, i / 2), got, exp);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL stall i=%0d: got %h want %h", i, got, exp);
      end
      if (got[W+2]) loads++;
    end
    total++;
    if (loads !== 1 || bus.word !== 16'h1234) begin
      bad++; $display("FAIL stall_result: loads=%0d word=%h want 1 1234", loads, bus.word);
    end
  endtask

  task automatic test_abort();
    logic [W+2:0] got, exp;
    int loads = 0, errs = 0;
    logic [W-1:0] word0;
    word0 = m_word;
    for (int k = 0; k < 9 + 1 + FL + 3; k++) begin
      if (k == 0 || k == 9) step(1'b1, 1'b0, 1'b0, got, exp);
      else if (k < 9) step(1'b0, 1'b1, 1'b1, got, exp);
      else if (k <= 9 + FL) step(1'b0, 1'b1, fbit(16'h0F0F, k - 10), got, exp);
      else step(1'b0, 1'b0, 1'b0, got, exp);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL abort k=%0d: got %h want %h", k, got, exp);
      end
      if (got[W+2]) loads++;
      if (got[W+1]) errs++;
      if (k == 9) begin
        total++;
        if (bus.err !== 1'b1 || bus.word !== word0) begin
          bad++; $display("FAIL abort_pulse: err=%b word=%h want 1 %h", bus.err, bus.word, word0);
        end
      end
    end
    total++;
    if (loads !== 1 || errs !== 1 || bus.word !== 16'h0F0F) begin
      bad++; $display("FAIL abort_result: loads=%0d errs=%0d word=%h want 1 1 0f0f",
                      loads, errs, bus.word);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] got, exp;
    int lt[$];
    logic [W-1:0] lw[$];
    int n = 0;
    for (int k = 0; k < 2 * (FL + 1) + 2; k++) begin
      if (k == 0 || k == FL + 1) step(1'b1, 1'b0, 1'b0, got, exp);
      else if (k <= FL) step(1'b0, 1'b1, fbit(16'hAAAA, k - 1), got, exp);
      else if (k <= 2 * FL + 1) step(1'b0, 1'b1, fbit(16'h5555, k - FL - 2), got, exp);
      else step(1'b0, 1'b0, 1'b0, got, exp);
      n++;
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL b2b k=%0d: got %h want %h", k, got, exp);
      end
      if (got[W+2]) begin lt.push_back(n); lw.push_back(got[W-1:0]); end
    end
    total++;
    if (lt.size() !== 2) begin
      bad++; $display("FAIL b2b_count: got %0d loads want 2", lt.size());
    end else begin
      total++;
      if (lt[0] !== FL + 1 || lt[1] !== 2 * (FL + 1) || lw[0] !== 16'hAAAA || lw[1] !== 16'h5555)
      begin
        bad++; $display("FAIL b2b_timing: t%0d=%h t%0d=%h want t%0d=aaaa t%0d=5555",
                        lt[0], lw[0], lt[1], lw[1], FL + 1, 2 * (FL + 1));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W+2:0] got, exp;
    int loads = 0;
    step(1'b1, 1'b0, 1'b0, got, exp);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, fbit(16'hBEEF, i), got, exp);
    bus.start = 1'b0; bus.bit_valid = 1'b0; bus.sdata = 1'b0;
    #2 rst = 1'b1;
    #1;
    got = {bus.load, bus.err, bus.busy, bus.word};
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL async_reset: got %h want 0", got);
    end
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= FL + 2; k++) begin
      if (k == 0) step(1'b1, 1'b0, 1'b0, got, exp);
      else if (k <= FL) step(1'b0, 1'b1, fbit(16'hBEEF, k - 1), got, exp);
      else step(1'b0, 1'b0, 1'b0, got, exp);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL post_reset k=%0d: got %h want %h", k, got, exp);
      end
      if (got[W+2]) loads++;
    end
    total++;
    if (loads !== 1 || bus.word !== 16'hBEEF) begin
      bad++; $display("FAIL post_reset_result: loads=%0d word=%h want 1 beef", loads, bus.word);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    logic [W+2:0] got, exp;
    int loads = 0, load_at = -1, errs = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= W + 3; k++) begin
        if (k == 0) step(1'b1, 1'b0, 1'b0, got, exp);
        else if (k <= W) step(1'b0, 1'b1, fbit(16'h0001, k - 1), got, exp);
        else if (k == W + 1) step(1'b0, 1'b1, (f == 0) ? 1'b1 : 1'b0, got, exp);
        else step(1'b0, 1'b0, 1'b0, got, exp);
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL parity f=%0d k=%0d: got %h want %h", f, k, got, exp);
        end
        if (got[W+2]) begin loads++; load_at = k + 1; end
        if (got[W+1]) errs++;
      end
      if (f == 0) begin
        total++;
        if (loads !== 1 || load_at !== 18 || errs !== 0) begin
          bad++; $display("FAIL parity_good: loads=%0d at t%0d errs=%0d want 1 t18 0",
                          loads, load_at, errs);
        end
      end
    end
    total++;
    if (loads !== 1 || errs !== 1 || bus.word !== 16'h0001) begin
      bad++; $display("FAIL parity_bad: loads=%0d errs=%0d word=%h want 1 1 0001",
                      loads, errs, bus.word);
    end
  endtask
`endif

  task automatic test_random();
    logic [W+2:0] got, exp;
    logic s, v;
    for (int i = 0; i < 600; i++) begin
      if (i >= 590) begin
        s = 1'b0; v = 1'b0;
      end else begin
        s = m_active ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
        v = ($urandom_range(0, 3) != 0);
      end
      step(s, v, 1'($urandom), got, exp);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random i=%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
